// File: rtl/posit_pkg.sv
// -----------------------------------------------------------------------------
// posit_pkg
// Shared definitions for the posit8 dot-product sequencer:
//   - dot_state_t : sequencer FSM states
//   - POSIT8_NAR / POSIT8_ZERO / POSIT8_ONE : posit8 (es=0) special encodings
//   - is_nar()    : NaR detector for a posit8 word
// -----------------------------------------------------------------------------
package posit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DRAIN,
      ST_CAPT,
      ST_OUT
   } dot_state_t;

   localparam logic [7:0] POSIT8_NAR  = 8'h80;
   localparam logic [7:0] POSIT8_ZERO = 8'h00;
   localparam logic [7:0] POSIT8_ONE  = 8'h40;

   function automatic logic is_nar(input logic [7:0] p);
      return (p == POSIT8_NAR);
   endfunction

endpackage

// File: rtl/posit_dot_issue.sv
// -----------------------------------------------------------------------------
// posit_dot_issue
// Operand issue register feeding the posit8 MAC. An accepted pair is captured
// into mac_a/mac_b and mac_en is raised for exactly the following cycle; with
// no accept the operands hold and mac_en is low.
//
// Optional feature (macro POSIT_DOT_NAR_STICKY_EN):
//   A sticky NaR flag clears on clr and sets on any accepted pair carrying a
//   NaR operand. While set (including the NaR pair itself) mac_en is held low,
//   so the accumulator is frozen; nar_sticky tells the result stage to report
//   NaR. Without the macro NaR operands pass straight through.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : sticky flag clear (high during the sequencer's CLEAR cycle)
//   accept       : operand pair accepted this cycle
//   s_a, s_b     : incoming posit8 operands
//   mac_a, mac_b : registered operands to the MAC
//   mac_en       : registered MAC accumulate enable
//   nar_sticky   : sticky NaR flag (constant 0 without the macro)
// -----------------------------------------------------------------------------
module posit_dot_issue
   import posit_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       accept,
   input  logic [7:0] s_a,
   input  logic [7:0] s_b,
   output logic [7:0] mac_a,
   output logic [7:0] mac_b,
   output logic       mac_en,
   output logic       nar_sticky
);

   logic [7:0] mac_a_reg;
   logic [7:0] mac_b_reg;
   logic       mac_en_reg;
   logic       mac_en_next;

`ifdef POSIT_DOT_NAR_STICKY_EN
   logic sticky_reg;
   logic pair_nar;

   assign pair_nar = is_nar(s_a) || is_nar(s_b);

   // The NaR pair itself is also suppressed: the result is NaR regardless.
   assign mac_en_next = accept && !sticky_reg && !pair_nar;
   assign nar_sticky  = sticky_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_reg <= 1'b0;
      end else if (clr) begin
         sticky_reg <= 1'b0;
      end else if (accept && pair_nar) begin
         sticky_reg <= 1'b1;
      end
   end
`else
   logic unused_clr;

   assign unused_clr  = clr;
   assign mac_en_next = accept;
   assign nar_sticky  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mac_a_reg  <= POSIT8_ZERO;
         mac_b_reg  <= POSIT8_ZERO;
         mac_en_reg <= 1'b0;
      end else begin
         mac_en_reg <= mac_en_next;
         if (accept) begin
            mac_a_reg <= s_a;
            mac_b_reg <= s_b;
         end
      end
   end

   assign mac_a  = mac_a_reg;
   assign mac_b  = mac_b_reg;
   assign mac_en = mac_en_reg;

endmodule

// File: rtl/posit_dot_seq.sv
// -----------------------------------------------------------------------------
// posit_dot_seq
// Dot-product sequencer upstream of a posit8 MAC. Takes (A,B) operand pairs
// on a valid/ready stream, issues one per cycle to the MAC, clears the
// accumulator at the start of each vector, and returns the final accumulator
// as a single result beat.
//
// FSM: IDLE -> CLEAR -> RUN -> DRAIN -> CAPT -> OUT -> IDLE
//      IDLE -> OUT directly for a zero-length vector (result 0, no MAC clear).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, cfg_len    : begin a vector of cfg_len pairs (sampled in IDLE only)
//   busy              : state != IDLE
//   s_valid/s_ready   : operand stream handshake, s_a / s_b operands
//   mac_a/mac_b       : registered operands to the MAC
//   mac_en            : MAC accumulates on this cycle's edge
//   mac_clr           : one-cycle accumulator clear
//   mac_acc           : MAC accumulator (registered inside the MAC)
//   m_valid/m_ready   : result handshake, m_data result, m_nar = (m_data==NaR)
//
// Optional feature: POSIT_DOT_NAR_STICKY_EN (see posit_dot_issue) forces a
// NaR result once any NaR operand has been accepted in the vector.
// -----------------------------------------------------------------------------
module posit_dot_seq
   import posit_pkg::*;
#(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             busy,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_a,
   input  logic [7:0]       s_b,
   output logic [7:0]       mac_a,
   output logic [7:0]       mac_b,
   output logic             mac_en,
   output logic             mac_clr,
   input  logic [7:0]       mac_acc,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [7:0]       m_data,
   output logic             m_nar
);

   dot_state_t       state_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] cnt_reg;
   logic             s_ready_reg;
   logic             mac_clr_reg;
   logic             m_valid_reg;
   logic [7:0]       m_data_reg;
   logic             m_nar_reg;

   logic             accept;
   logic             last_pair;
   logic             nar_sticky;
   logic [7:0]       capt_data;

   // s_ready_reg is only ever high in RUN, so s_valid is ignored elsewhere.
   assign accept    = s_valid && s_ready_reg;
   assign last_pair = (cnt_reg == len_reg - LEN_W'(1));
   assign capt_data = nar_sticky ? POSIT8_NAR : mac_acc;

   posit_dot_issue u_issue (
      .clk        (clk),
      .rst        (rst),
      .clr        (mac_clr_reg),
      .accept     (accept),
      .s_a        (s_a),
      .s_b        (s_b),
      .mac_a      (mac_a),
      .mac_b      (mac_b),
      .mac_en     (mac_en),
      .nar_sticky (nar_sticky)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         len_reg     <= '0;
         cnt_reg     <= '0;
         s_ready_reg <= 1'b0;
         mac_clr_reg <= 1'b0;
         m_valid_reg <= 1'b0;
         m_data_reg  <= POSIT8_ZERO;
         m_nar_reg   <= 1'b0;
      end else begin
         mac_clr_reg <= 1'b0;
         unique case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  len_reg <= cfg_len;
                  cnt_reg <= '0;
                  if (cfg_len == '0) begin
                     m_data_reg  <= POSIT8_ZERO;
                     m_nar_reg   <= 1'b0;
                     m_valid_reg <= 1'b1;
                     state_reg   <= ST_OUT;
                  end else begin
                     mac_clr_reg <= 1'b1;
                     state_reg   <= ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               s_ready_reg <= 1'b1;
               state_reg   <= ST_RUN;
            end
            ST_RUN: begin
               if (accept) begin
                  cnt_reg <= cnt_reg + LEN_W'(1);
                  if (last_pair) begin
                     s_ready_reg <= 1'b0;
                     state_reg   <= ST_DRAIN;
                  end
               end
            end
            // mac_en for the last pair is high here; the MAC updates at the
            // end of this cycle, so the accumulator is final in CAPT.
            ST_DRAIN: begin
               state_reg <= ST_CAPT;
            end
            ST_CAPT: begin
               m_data_reg  <= capt_data;
               m_nar_reg   <= (capt_data == POSIT8_NAR);
               m_valid_reg <= 1'b1;
               state_reg   <= ST_OUT;
            end
            ST_OUT: begin
               if (m_ready) begin
                  m_valid_reg <= 1'b0;
                  state_reg   <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy    = (state_reg != ST_IDLE);
   assign s_ready = s_ready_reg;
   assign mac_clr = mac_clr_reg;
   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign m_nar   = m_nar_reg;

endmodule

// File: tb/tb_posit_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_posit_dot_seq
// Self-checking bench for posit_dot_seq. A behavioural posit8 MAC is attached
// to the mac_* port; expected results come from folding the same posit8
// arithmetic (decode to real, add/multiply, round to nearest posit8) over the
// pair list. Directed scenarios are followed by randomized vectors.
// -----------------------------------------------------------------------------
module tb_posit_dot_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] cfg_len;
   logic       busy;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_a;
   logic [7:0] s_b;
   logic [7:0] mac_a;
   logic [7:0] mac_b;
   logic       mac_en;
   logic       mac_clr;
   logic [7:0] mac_acc = 8'h00;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_nar;

   int tests = 0;
   int fails = 0;

   int en_cnt     = 0;
   int clr_cnt    = 0;
   int nar_en_cnt = 0;

   logic [7:0] pa [256];
   logic [7:0] pb [256];
   logic [7:0] last_data;

   posit_dot_seq #(.LEN_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .cfg_len (cfg_len),
      .busy    (busy),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_a     (s_a),
      .s_b     (s_b),
      .mac_a   (mac_a),
      .mac_b   (mac_b),
      .mac_en  (mac_en),
      .mac_clr (mac_clr),
      .mac_acc (mac_acc),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_nar   (m_nar)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- posit8 (es=0) arithmetic ----------------
   function automatic real p2r(input logic [7:0] p);
      logic [7:0] v;
      logic       r;
      int         m, i, k, nf, fr;
      real        f, sc, val;
      if (p == 8'h00) return 0.0;
      v = p[7] ? (8'd0 - p) : p;
      r = v[6];
      m = 0;
      i = 6;
      while (i >= 0 && v[3'(i)] == r) begin
         m++;
         i--;
      end
      i--;
      k  = r ? m - 1 : -m;
      nf = (i >= 0) ? i + 1 : 0;
      fr = int'(v) & ((1 << nf) - 1);
      f  = real'(fr) / real'(1 << nf);
      sc = 1.0;
      if (k >= 0) for (int j = 0; j < k; j++) sc = sc * 2.0;
      else        for (int j = 0; j < -k; j++) sc = sc * 0.5;
      val = sc * (1.0 + f);
      return p[7] ? -val : val;
   endfunction

   function automatic logic [7:0] r2p(input real x);
      logic [7:0] best, c;
      real        d, bd;
      best = 8'h00;
      bd   = (x < 0.0) ? -x : x;
      for (int n = 1; n < 256; n++) begin
         c = 8'(n);
         if (c != 8'h80) begin
            d = p2r(c) - x;
            if (d < 0.0) d = -d;
            if (d < bd || (d == bd && !c[0] && best[0])) begin
               best = c;
               bd   = d;
            end
         end
      end
      if (best == 8'h00 && x != 0.0) best = (x > 0.0) ? 8'h01 : 8'hFF;
      return best;
   endfunction

   function automatic logic [7:0] pmac(input logic [7:0] acc, input logic [7:0] a,
                                       input logic [7:0] b);
      if (acc == 8'h80 || a == 8'h80 || b == 8'h80) return 8'h80;
      return r2p(p2r(acc) + p2r(a) * p2r(b));
   endfunction

   // Behavioural MAC: not touched by rst, only by mac_clr.
   always @(posedge clk) begin
      if (mac_clr)     mac_acc <= 8'h00;
      else if (mac_en) mac_acc <= pmac(mac_acc, mac_a, mac_b);
   end

   always @(posedge clk) begin
      if (mac_en)                  en_cnt     <= en_cnt + 1;
      if (mac_clr)                 clr_cnt    <= clr_cnt + 1;
      if (mac_en && mac_a == 8'h80) nar_en_cnt <= nar_en_cnt + 1;
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_busy"},    32'(busy),    0);
      check({tag, "_s_ready"}, 32'(s_ready), 0);
      check({tag, "_mac_a"},   32'(mac_a),   0);
      check({tag, "_mac_b"},   32'(mac_b),   0);
      check({tag, "_mac_en"},  32'(mac_en),  0);
      check({tag, "_mac_clr"}, 32'(mac_clr), 0);
      check({tag, "_m_valid"}, 32'(m_valid), 0);
      check({tag, "_m_data"},  32'(m_data),  0);
      check({tag, "_m_nar"},   32'(m_nar),   0);
   endtask

   // Runs one vector of len pairs from pa/pb.
   //   gap_max   : random idle cycles (0..gap_max) between pairs when fixed_gap < 0
   //   fixed_gap : exact idle cycles between pairs when >= 0
   //   rdy_delay : cycles m_ready is held low in OUT; negative = m_ready high early
   task automatic run_vec(input string tag, input int len, input int gap_max,
                          input int fixed_gap, input int rdy_delay);
      logic [7:0] exp_d;
      int         en_exp, en0, clr0, idx, gap, cyc, guard, lat_exp;
      bit         seen_nar, acc;
      exp_d    = 8'h00;
      en_exp   = 0;
      seen_nar = 1'b0;
      for (int i = 0; i < len; i++) begin
         exp_d = pmac(exp_d, pa[i], pb[i]);
         if (pa[i] == 8'h80 || pb[i] == 8'h80) seen_nar = 1'b1;
         if (!seen_nar) en_exp++;
      end
`ifndef POSIT_DOT_NAR_STICKY_EN
      en_exp = len;
`endif
      en0  = en_cnt;
      clr0 = clr_cnt;

      m_ready = (rdy_delay < 0);
      start   = 1'b1;
      cfg_len = 8'(len);
      step();
      start = 1'b0;
      cyc   = 1;
      idx   = 0;
      gap   = 0;
      guard = 0;
      while (idx < len && guard < 2000) begin
         if (gap > 0) begin
            s_valid = 1'b0;
            gap--;
         end else begin
            s_valid = 1'b1;
            s_a     = pa[idx];
            s_b     = pb[idx];
         end
         acc = s_valid && s_ready;
         step();
         cyc++;
         guard++;
         if (acc) begin
            idx++;
            gap = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(gap_max, 0));
         end
      end
      s_valid = 1'b0;
      check({tag, "_accepts"}, idx, len);

      guard = 0;
      while (!m_valid && guard < 100) begin
         step();
         cyc++;
         guard++;
      end
      check({tag, "_m_valid"}, 32'(m_valid), 1);
      if (fixed_gap >= 0 || gap_max == 0) begin
         lat_exp = (len == 0) ? 1 : len + 4 + (len - 1) * ((fixed_gap > 0) ? fixed_gap : 0);
         check({tag, "_latency"}, cyc, lat_exp);
      end
      check({tag, "_m_data"}, 32'(m_data), 32'(exp_d));
      check({tag, "_m_nar"},  32'(m_nar),  32'(exp_d == 8'h80));
      check({tag, "_busy"},   32'(busy),   1);
      last_data = m_data;

      for (int k = 0; k < rdy_delay; k++) begin
         m_ready = 1'b0;
         start   = (k % 2 == 0);
         step();
         check({tag, "_hold_valid"}, 32'(m_valid), 1);
         check({tag, "_hold_data"},  32'(m_data),  32'(exp_d));
         check({tag, "_hold_busy"},  32'(busy),    1);
      end
      start   = 1'b0;
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      check({tag, "_consumed"},  32'(m_valid), 0);
      check({tag, "_idle"},      32'(busy),    0);
      check({tag, "_en_cycles"}, en_cnt - en0, en_exp);
      check({tag, "_clr_pulses"}, clr_cnt - clr0, (len == 0) ? 0 : 1);
      $display("[TB] vector %s len=%0d result=0x%02h expected=0x%02h", tag, len, last_data, exp_d);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int nar0;
      rst     = 1'b1;
      start   = 1'b0;
      cfg_len = 8'd0;
      s_valid = 1'b0;
      s_a     = 8'h00;
      s_b     = 8'h00;
      m_ready = 1'b0;
      step();
      step();
      check_reset("reset");
      rst = 1'b0;
      step();

      // len=3, 1.0*1.0 three times back-to-back -> 3.0
      for (int i = 0; i < 3; i++) begin
         pa[i] = 8'h40;
         pb[i] = 8'h40;
      end
      run_vec("len3", 3, 0, 0, 0);
      check("len3_const", 32'(last_data), 32'h68);

      // len=2 with a 2-cycle gap: 1.5*0.5... here 2.0*0.5 + 1.0*1.0 -> 2.0
      pa[0] = 8'h60; pb[0] = 8'h20;
      pa[1] = 8'h40; pb[1] = 8'h40;
      run_vec("gap2", 2, 0, 2, 0);
      check("gap2_const", 32'(last_data), 32'h60);

      // zero-length vector
      run_vec("len0", 0, 0, 0, 0);
      check("len0_const", 32'(last_data), 32'h00);

      // result held 5 cycles with start pulses during OUT
      for (int i = 0; i < 3; i++) begin
         pa[i] = 8'(8'h30 + i);
         pb[i] = 8'h48;
      end
      run_vec("hold5", 3, 0, 0, 5);

      // reset after 1 of 4 pairs
      start   = 1'b1;
      cfg_len = 8'd4;
      step();
      start   = 1'b0;
      s_valid = 1'b1;
      s_a     = 8'h40;
      s_b     = 8'h40;
      step();
      step();
      s_valid = 1'b0;
      rst     = 1'b1;
      step();
      check_reset("midrst");
      rst = 1'b0;
      pa[0] = 8'h40;
      pb[0] = 8'h40;
      run_vec("after_rst", 1, 0, 0, 0);
      check("after_rst_const", 32'(last_data), 32'h40);

      // NaR operand mid-vector
      pa[0] = 8'h40; pb[0] = 8'h40;
      pa[1] = 8'h80; pb[1] = 8'h40;
      pa[2] = 8'h40; pb[2] = 8'h40;
      nar0 = nar_en_cnt;
      run_vec("nar", 3, 0, 0, 0);
      check("nar_const", 32'(last_data), 32'h80);
`ifdef POSIT_DOT_NAR_STICKY_EN
      check("nar_issued_en", nar_en_cnt - nar0, 0);
`else
      check("nar_issued_en", nar_en_cnt - nar0, 1);
`endif

      // m_ready held high before the result appears
      pa[0] = 8'h50; pb[0] = 8'h40;
      pa[1] = 8'h40; pb[1] = 8'h38;
      run_vec("early_rdy", 2, 0, 0, -1);

      // randomized vectors
      for (int v = 0; v < 24; v++) begin
         int len, gmax, rd;
         len  = int'($urandom_range(10, 0));
         gmax = int'($urandom_range(2, 0));
         rd   = int'($urandom_range(3, 0)) - 1;
         for (int i = 0; i < len; i++) begin
            pa[i] = 8'($urandom_range(255, 0));
            pb[i] = 8'($urandom_range(255, 0));
         end
         run_vec($sformatf("rnd%0d", v), len, gmax, -1, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
